// File: rtl/ras_ctrl_if.sv
// Fetch-side handshake between the decode stream and ras_ctrl: instruction
// offer/accept, in-order branch resolution and the return-address prediction.
interface ras_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             fetch_valid;
    logic             fetch_ready;
    logic             is_call;
    logic             is_ret;
    logic             is_cond;
    logic             is_rvc;
    logic [WIDTH-1:0] pc;
    logic             resolve_valid;
    logic             resolve_mispredict;
    logic             pred_valid;
    logic [WIDTH-1:0] pred_target;
    logic             pred_none;

    modport master (
        output fetch_valid, is_call, is_ret, is_cond, is_rvc, pc,
               resolve_valid, resolve_mispredict,
        input  fetch_ready, pred_valid, pred_target, pred_none
    );

    modport slave (
        input  fetch_valid, is_call, is_ret, is_cond, is_rvc, pc,
               resolve_valid, resolve_mispredict,
        output fetch_ready, pred_valid, pred_target, pred_none
    );
endinterface

// File: rtl/ras_ctrl.sv
// Speculation/sequencing controller in front of the return address stack.
// Optional RAS_CTRL_STATS_EN adds saturating ret/pred_none/mispredict counters.
module ras_ctrl #(
    parameter int WIDTH          = 32,
    parameter int MAXBRANCHES    = 16,
    parameter int BRANCHES_ADDR  = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    ras_ctrl_if.slave        fe,
    output logic             ras_push,
    output logic             ras_pop,
    output logic             ras_branch,
    output logic             ras_close_valid,
    output logic             ras_close_invalid,
    output logic [WIDTH-1:0] ras_din,
    input  logic [WIDTH-1:0] ras_dout,
    input  logic             ras_empty
`ifdef RAS_CTRL_STATS_EN
    ,
    output logic [15:0]      stat_ret,
    output logic [15:0]      stat_none,
    output logic [15:0]      stat_mispredict
`endif
);
    localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [BRANCHES_ADDR:0] CNT_ONE  = 1;
    localparam logic [BRANCHES_ADDR:0] CNT_FULL = MAXBRANCHES;

    typedef enum logic {RUN, RECOVER} state_t;

    state_t                 state;
    logic [BRANCHES_ADDR:0] outstanding;
    logic [REC_W-1:0]       rec_cnt;
    logic                   bypass_valid;
    logic [WIDTH-1:0]       last_din;
    logic                   pred_use_dout;
    logic [WIDTH-1:0]       pred_byp;

    logic run, resolve_live, mispredict, correct, full, accept, ret_acc, bypass_hit;

    // rst_n gates everything so strobes are quiet for the whole reset assertion.
    assign run          = rst_n && (state == RUN);
    assign resolve_live = run && fe.resolve_valid && (outstanding != '0);
    assign mispredict   = resolve_live && fe.resolve_mispredict;
    assign correct      = resolve_live && !fe.resolve_mispredict;
    assign full         = (outstanding == CNT_FULL);
    assign fe.fetch_ready = run && !mispredict && !(fe.is_cond && full && !correct);
    assign accept       = fe.fetch_valid && fe.fetch_ready;
    assign ret_acc      = accept && fe.is_ret;
    // Call+ret in one cycle reads the old top from the ras, so no bypass.
    assign bypass_hit   = bypass_valid && !fe.is_call;

    assign ras_push          = accept && fe.is_call;
    assign ras_pop           = ret_acc && !ras_empty;
    assign ras_branch        = accept && fe.is_cond;
    assign ras_close_valid   = correct;
    assign ras_close_invalid = mispredict;
    assign ras_din           = fe.pc + (fe.is_rvc ? WIDTH'(2) : WIDTH'(4));

    assign fe.pred_target = pred_use_dout ? ras_dout : pred_byp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            outstanding   <= '0;
            rec_cnt       <= '0;
            bypass_valid  <= 1'b0;
            last_din      <= '0;
            fe.pred_valid <= 1'b0;
            fe.pred_none  <= 1'b0;
            pred_use_dout <= 1'b0;
            pred_byp      <= '0;
`ifdef RAS_CTRL_STATS_EN
            stat_ret        <= '0;
            stat_none       <= '0;
            stat_mispredict <= '0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (mispredict) begin
                        outstanding <= '0;
                        rec_cnt     <= REC_W'(RECOVER_CYCLES - 1);
                        state       <= RECOVER;
                    end else begin
                        case ({ras_branch, ras_close_valid})
                            2'b10:   outstanding <= outstanding + CNT_ONE;
                            2'b01:   outstanding <= outstanding - CNT_ONE;
                            default: outstanding <= outstanding;
                        endcase
                    end
                end
                RECOVER: begin
                    if (rec_cnt == '0) state <= RUN;
                    else               rec_cnt <= rec_cnt - 1'b1;
                end
                default: state <= RUN;
            endcase

            bypass_valid  <= accept && fe.is_call && !fe.is_ret;
            if (ras_push) last_din <= ras_din;

            fe.pred_valid <= ret_acc;
            fe.pred_none  <= ret_acc && !bypass_hit && ras_empty;
            pred_use_dout <= ret_acc && !bypass_hit && !ras_empty;
            pred_byp      <= (ret_acc && bypass_hit) ? last_din : '0;

`ifdef RAS_CTRL_STATS_EN
            if (ret_acc && stat_ret != '1) stat_ret <= stat_ret + 1'b1;
            if (ret_acc && !bypass_hit && ras_empty && stat_none != '1)
                stat_none <= stat_none + 1'b1;
            if (mispredict && stat_mispredict != '1)
                stat_mispredict <= stat_mispredict + 1'b1;
`endif
        end
    end
endmodule
